// File: rtl/parking_pkg.sv
// Shared constants for the parking sensor input-conditioning path.
// Channel defaults and the bit positions of each sensor in the fault vector.
package parking_pkg;

    localparam int SENSOR_SYNC_STAGES     = 2;
    localparam int SENSOR_DEBOUNCE_CYCLES = 16;
    localparam int SENSOR_STUCK_CYCLES    = 65535;

    localparam int NUM_SENSORS    = 2;
    localparam int FAULT_ENTRANCE = 0;
    localparam int FAULT_EXIT     = 1;

endpackage

// File: rtl/sensor_debounce_channel.sv
// One sensor channel: synchroniser, debounce filter, rise pulse and a sticky
// stuck-high detector.
module sensor_debounce_channel
    import parking_pkg::*;
#(
    parameter int SYNC_STAGES     = SENSOR_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = SENSOR_STUCK_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic fault_clear,
    output logic clean,
    output logic rise,
    output logic stuck
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int STK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic [STK_W-1:0]       stk_cnt_q, stk_cnt_d;
    logic                   stuck_q, stuck_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        synced = sync_q[SYNC_STAGES-1];
    end

    // A disagreement must persist DEBOUNCE_CYCLES cycles; any agreement restarts it.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        clean_d   = clean_q;
        if (synced == clean_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            clean_d   = synced;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
        rise_d = clean_d & ~clean_q;
    end

    // Clear has priority; a still-saturated counter re-raises the flag next edge.
    always_comb begin
        stk_cnt_d = stk_cnt_q;
        if (!clean_q) begin
            stk_cnt_d = '0;
        end else if (stk_cnt_q != STK_MAX) begin
            stk_cnt_d = stk_cnt_q + 1'b1;
        end
        if (fault_clear) begin
            stuck_d = 1'b0;
        end else begin
            stuck_d = stuck_q | (stk_cnt_d == STK_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            clean_q   <= 1'b0;
            rise_q    <= 1'b0;
            stk_cnt_q <= '0;
            stuck_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            stk_cnt_q <= stk_cnt_d;
            stuck_q   <= stuck_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign stuck = stuck_q;

endmodule

// File: rtl/parking_sensor_filter.sv
// Conditions the raw entrance/exit sensors for the parking controller using
// two independent debounce channels.
module parking_sensor_filter
    import parking_pkg::*;
#(
    parameter int SYNC_STAGES     = SENSOR_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = SENSOR_STUCK_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       fault_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic       entrance_rise,
    output logic       exit_rise,
    output logic [1:0] stuck_fault
);

    logic [NUM_SENSORS-1:0] raw_vec, clean_vec, rise_vec, stuck_vec;

    assign raw_vec[FAULT_ENTRANCE] = raw_entrance;
    assign raw_vec[FAULT_EXIT]     = raw_exit;

    for (genvar ch = 0; ch < NUM_SENSORS; ch++) begin : g_ch
        sensor_debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (raw_vec[ch]),
            .fault_clear(fault_clear),
            .clean      (clean_vec[ch]),
            .rise       (rise_vec[ch]),
            .stuck      (stuck_vec[ch])
        );
    end

    assign sensor_entrance = clean_vec[FAULT_ENTRANCE];
    assign sensor_exit     = clean_vec[FAULT_EXIT];
    assign entrance_rise   = rise_vec[FAULT_ENTRANCE];
    assign exit_rise       = rise_vec[FAULT_EXIT];
    assign stuck_fault     = stuck_vec;

endmodule

// File: tb/tb_parking_sensor_filter.sv
// Directed bench for parking_sensor_filter with SYNC=2, DEBOUNCE=4, STUCK=20.
module tb_parking_sensor_filter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       raw_entrance = 1'b0;
    logic       raw_exit = 1'b0;
    logic       fault_clear = 1'b0;
    logic       sensor_entrance, sensor_exit, entrance_rise, exit_rise;
    logic [1:0] stuck_fault;

    int n_cmp = 0;
    int n_err = 0;

    parking_sensor_filter #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STUCK_CYCLES(20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_entrance(raw_entrance), .raw_exit(raw_exit),
        .fault_clear(fault_clear), .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
        .entrance_rise(entrance_rise), .exit_rise(exit_rise), .stuck_fault(stuck_fault)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; all sampling and driving happens 1ns after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; raw_entrance = 1'b0; raw_exit = 1'b0; fault_clear = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; raw_entrance = 1'b1; raw_exit = 1'b1; fault_clear = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({sensor_entrance, sensor_exit, entrance_rise, exit_rise, stuck_fault} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {sensor_entrance, sensor_exit, entrance_rise, exit_rise, stuck_fault});
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step();
            n_cmp++;
            if ({sensor_entrance, sensor_exit} !== ((n >= 6) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL reset_release_sensor edge %0d: got %b%b", n, sensor_entrance, sensor_exit);
            end
            n_cmp++;
            if ({entrance_rise, exit_rise} !== ((n == 6) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL reset_release_rise edge %0d: got %b%b", n, entrance_rise, exit_rise);
            end
        end
    endtask

    task automatic test_clean_edge();
        do_reset();
        raw_entrance = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step();
            n_cmp++;
            if (sensor_entrance !== (n >= 6)) begin
                n_err++;
                $display("FAIL clean_rise_level edge %0d: got %b want %b", n, sensor_entrance, n >= 6);
            end
            n_cmp++;
            if (entrance_rise !== (n == 6)) begin
                n_err++;
                $display("FAIL clean_rise_pulse edge %0d: got %b want %b", n, entrance_rise, n == 6);
            end
        end
        n_cmp++;
        if ({sensor_exit, exit_rise} !== 2'b00) begin
            n_err++;
            $display("FAIL clean_exit_isolated: got %b%b want 00", sensor_exit, exit_rise);
        end
        raw_entrance = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            step();
            n_cmp++;
            if (sensor_entrance !== (n < 6)) begin
                n_err++;
                $display("FAIL clean_fall_level edge %0d: got %b want %b", n, sensor_entrance, n < 6);
            end
            n_cmp++;
            if (entrance_rise !== 1'b0) begin
                n_err++;
                $display("FAIL clean_fall_no_pulse edge %0d: got %b want 0", n, entrance_rise);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        raw_exit = 1'b1;
        repeat (3) step();
        raw_exit = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            n_cmp++;
            if ({sensor_exit, exit_rise} !== 2'b00) begin
                n_err++;
                $display("FAIL glitch_single cycle %0d: got %b%b want 00", n, sensor_exit, exit_rise);
            end
        end
        for (int i = 0; i < 50; i++) begin
            raw_exit = (i % 4) != 3;
            step();
            n_cmp++;
            if ({sensor_exit, exit_rise} !== 2'b00) begin
                n_err++;
                $display("FAIL glitch_toggle cycle %0d: got %b%b want 00", i, sensor_exit, exit_rise);
            end
        end
        raw_exit = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_stuck();
        do_reset();
        raw_entrance = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (sensor_entrance !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_clean_up: got %b want 1", sensor_entrance);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k >= 18) begin
                n_cmp++;
                if (stuck_fault !== ((k == 20) ? 2'b01 : 2'b00)) begin
                    n_err++;
                    $display("FAIL stuck_set edge +%0d: got %b want %b", k, stuck_fault,
                             (k == 20) ? 2'b01 : 2'b00);
                end
            end
        end
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        n_cmp++;
        if (stuck_fault !== 2'b00) begin
            n_err++;
            $display("FAIL stuck_clear_wins: got %b want 00", stuck_fault);
        end
        step();
        n_cmp++;
        if (stuck_fault !== 2'b01) begin
            n_err++;
            $display("FAIL stuck_reassert: got %b want 01", stuck_fault);
        end
        raw_entrance = 1'b0;
        repeat (6) step();
        n_cmp++;
        if ({sensor_entrance, stuck_fault} !== 3'b001) begin
            n_err++;
            $display("FAIL stuck_sticky_after_drop: got %b want 001", {sensor_entrance, stuck_fault});
        end
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (stuck_fault !== 2'b00) begin
                n_err++;
                $display("FAIL stuck_cleared cycle %0d: got %b want 00", k, stuck_fault);
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        raw_entrance = 1'b1;
        raw_exit = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step();
            n_cmp++;
            if ({sensor_entrance, sensor_exit, entrance_rise, exit_rise} !==
                {(n >= 6) ? 2'b11 : 2'b00, (n == 6) ? 2'b11 : 2'b00}) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: got %b", n,
                         {sensor_entrance, sensor_exit, entrance_rise, exit_rise});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw_entrance = 1'b1;
        repeat (5) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_cmp++;
        if ({sensor_entrance, entrance_rise} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_discard: got %b%b want 00", sensor_entrance, entrance_rise);
        end
        for (int n = 1; n <= 6; n++) begin
            step();
            n_cmp++;
            if (sensor_entrance !== (n == 6)) begin
                n_err++;
                $display("FAIL reset_mid_latency edge %0d: got %b want %b", n, sensor_entrance, n == 6);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_glitch();
        test_stuck();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
